// File: rtl/stream_stat_ctrl.sv
// Streaming word-statistics engine: assembles input beats into words and reports
// ones count, sign changes and longest 1/0 runs through a two-deep result pipeline.
module stream_stat_ctrl #(
  parameter int WORD_SIZE = 256,
  parameter int IN_WIDTH  = 8,
  localparam int BEATS    = WORD_SIZE / IN_WIDTH,
  localparam int BIT_RES  = $clog2(WORD_SIZE) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic [BIT_RES-1:0]   ones,
  output logic [BIT_RES-1:0]   change_sign_count,
  output logic [BIT_RES-1:0]   ones_max_len,
  output logic [BIT_RES-1:0]   zeros_max_len,
  output logic [15:0]          word_cnt
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0]      LAST_IDX = CW'(BEATS - 1);
  localparam logic [BIT_RES-1:0] ONE      = BIT_RES'(1);

  logic [CW-1:0]        bcnt;
  logic [WORD_SIZE-1:0] asm_q;
  logic [WORD_SIZE-1:0] asm_next;
  logic [WORD_SIZE-1:0] w_q;
  logic                 wf;
  logic                 xfer;
  logic                 accept;
  logic                 last_beat;
  logic                 consume;

  logic [BIT_RES-1:0] ones_c;
  logic [BIT_RES-1:0] chg_c;
  logic [BIT_RES-1:0] max1_c;
  logic [BIT_RES-1:0] max0_c;
  logic [BIT_RES-1:0] run1;
  logic [BIT_RES-1:0] run0;

  // W drains whenever O is empty or being consumed; flush blocks intake outright
  assign xfer      = wf && (!out_valid || out_ready);
  assign in_ready  = !flush && (!wf || xfer);
  assign accept    = in_valid && in_ready;
  assign last_beat = (bcnt == LAST_IDX);
  assign consume   = out_valid && out_ready;

  always_comb begin
    asm_next = asm_q;
    for (int b = 0; b < BEATS; b++) begin
      if (bcnt == CW'(b)) begin
        asm_next[b*IN_WIDTH +: IN_WIDTH] = in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt  <= '0;
      asm_q <= '0;
    end else if (flush) begin
      bcnt <= '0;
    end else if (accept) begin
      asm_q <= asm_next;
      bcnt  <= last_beat ? '0 : bcnt + CW'(1);
    end
  end

  // A new last beat reloads W in the same cycle it drains, keeping wf high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wf  <= 1'b0;
      w_q <= '0;
    end else if (accept && last_beat) begin
      wf  <= 1'b1;
      w_q <= asm_next;
    end else if (xfer) begin
      wf <= 1'b0;
    end
  end

  always_comb begin
    ones_c = '0;
    chg_c  = '0;
    max1_c = '0;
    max0_c = '0;
    run1   = '0;
    run0   = '0;
    for (int i = 0; i < WORD_SIZE; i++) begin
      if (w_q[i]) begin
        ones_c = ones_c + ONE;
        run1   = run1 + ONE;
        run0   = '0;
        if (run1 > max1_c) max1_c = run1;
      end else begin
        run0 = run0 + ONE;
        run1 = '0;
        if (run0 > max0_c) max0_c = run0;
      end
    end
    for (int i = 1; i < WORD_SIZE; i++) begin
      if (w_q[i] != w_q[i-1]) chg_c = chg_c + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid         <= 1'b0;
      out_data          <= '0;
      ones              <= '0;
      change_sign_count <= '0;
      ones_max_len      <= '0;
      zeros_max_len     <= '0;
      word_cnt          <= '0;
    end else begin
      if (xfer) begin
        out_valid         <= 1'b1;
        out_data          <= w_q;
        ones              <= ones_c;
        change_sign_count <= chg_c;
        ones_max_len      <= max1_c;
        zeros_max_len     <= max0_c;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
      if (consume) begin
        word_cnt <= word_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/stream_stat_ctrl.md
# stream_stat_ctrl

Streaming word-statistics engine, next generation of the byte-serial statistics controller. It assembles IN_WIDTH-bit input beats into WORD_SIZE-bit words under a valid/ready handshake. For each word it computes the ones count, the sign-change count, and the longest runs of ones and zeros. Word plus statistics are presented on a backpressured output port; it sits between the raw sample source and the statistics consumer.

## Interface
Parameters:
- WORD_SIZE, 256: assembled word width; must be a multiple of IN_WIDTH.
- IN_WIDTH, 8: input beat width; must be ≥1.
- BEATS, WORD_SIZE/IN_WIDTH: beats per word (derived, ≥1).
- BIT_RES, $clog2(WORD_SIZE)+1: statistic width, so WORD_SIZE itself is representable.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous; discards the partial word in the assembler.
- in_valid  in  1  input beat valid.
- in_data  in  IN_WIDTH  input beat.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  WORD_SIZE  assembled word.
- ones  out  BIT_RES  population count of out_data.
- change_sign_count  out  BIT_RES  count of i in 1..WORD_SIZE-1 with out_data[i] != out_data[i-1].
- ones_max_len  out  BIT_RES  longest run of consecutive 1s in out_data.
- zeros_max_len  out  BIT_RES  longest run of consecutive 0s in out_data.
- word_cnt  out  16  number of results consumed; wraps at 65535→0.

## Operation
The block has three storage stages: assembler A, word register W (flag wf), and output register O (flag = out_valid).

Assembler A:
- Beat counter bcnt runs 0..BEATS-1.
- An accepted beat writes A[bcnt*IN_WIDTH +: IN_WIDTH], so beat 0 lands at the LSBs.
- bcnt wraps to 0 after beat BEATS-1.

Last-beat rule:
- An accepted beat with bcnt==BEATS-1 moves the complete word (including this beat) into W and sets wf.
- When BEATS==1, every beat is a last beat.

W to O transfer:
- xfer = wf && (!out_valid || out_ready).
- On xfer, O captures W together with all four statistics, computed combinationally from W. wf clears unless a new last beat loads W in the same cycle.

Input handshake:
- in_ready = !wf || xfer.
- Beats are held off only when W is occupied and cannot drain.

Output handshake:
- O holds stable while out_valid && !out_ready.
- out_valid drops after consumption unless xfer refills O in the same cycle.

flush:
- Clears bcnt and ignores any same-cycle input beat; in_ready is forced to 0 during flush.
- W, O and word_cnt are unaffected.

word_cnt increments on each out_valid && out_ready.

Statistics:
- Each statistic is computed within a single word only; no runs carry across words.
- All-ones word: ones = ones_max_len = WORD_SIZE, zeros_max_len = 0, change_sign_count = 0.
- All-zeros word: zeros_max_len = WORD_SIZE, all other statistics 0.

## Timing
Reset (asynchronous assertion):
- out_valid=0, wf=0, bcnt=0, word_cnt=0.
- out_data and all statistic outputs are 0.
- in_ready=1 once rst_n deasserts.
- Reset mid-word discards the partial word and any buffered results.

Latency and throughput:
- Last beat accepted at cycle t → wf at t+1 → out_valid at t+2 when out_ready is unstalled.
- Sustained throughput is one beat per cycle with no bubbles while out_ready stays high.
- With BEATS==1 this is one word per cycle.

Backpressure:
- With out_ready=0, at most one more word fills W.
- The next last beat is then refused (in_ready=0). Non-last beats are also refused, because in_ready is a single flag.
- No data is lost or duplicated.

Simultaneous events:
- Last beat loading W while W drains to O in the same cycle is legal; wf stays 1.
- Consume and xfer in the same cycle keeps out_valid=1 with the new result.
- flush on the same cycle as a last beat: flush wins, the beat is not accepted, and W is not loaded.

## Test plan
Use WORD_SIZE=32, IN_WIDTH=8 unless stated.
- Reset then 4 beats 0x01,0x00,0x00,0x80 with out_ready=1 → out_data=0x80000001, ones=2, change_sign_count=2, ones_max_len=1, zeros_max_len=30, out_valid 2 cycles after the 4th beat, word_cnt=1.
- Beats 0xFF×4, then 0x00×4, back-to-back → first result ones=32, ones_max_len=32, zeros_max_len=0, change_sign_count=0. Second result ones=0, zeros_max_len=32. Results arrive on consecutive words with in_ready held at 1.
- Word 0x0000FFF0 then 0x55555555, with out_ready=0 for 20 cycles → first result held stable. in_ready drops when the second word is in W and the next last beat arrives. On release both results emerge in order: change_sign_count=2 then 31, ones_max_len=12 then 1.
- Send 2 beats, assert flush one cycle, then 4 beats 0x0F,0x0F,0x0F,0x0F → a single result, 0x0F0F0F0F, with ones=16 and change_sign_count=7. The flushed beats never appear.
- Assert rst_n=0 mid-word with a result pending → all outputs immediately 0. After release, a fresh 4-beat word yields a correct result with word_cnt=1.
- Parameter sweep WORD_SIZE=64, IN_WIDTH=64 (BEATS=1), random words with out_ready randomly toggling → one result per accepted beat; statistics match a reference model; word_cnt equals consumed count.
